// File: rtl/oled_frame_arbiter.sv
// oled_frame_arbiter: round-robin arbiter granting one of two requesters a full OLED frame.
module oled_frame_arbiter #(
   parameter int NUM_ASCII_COL = 12,
   parameter int NUM_ASCII_ROW = 8,
   parameter int N_COLOR_BITS = 8,
   parameter int TIMEOUT_CYC = 1000,
   localparam int AW = NUM_ASCII_COL*NUM_ASCII_ROW*8
)(
   input  logic                    i_CLK,
   input  logic                    i_RST,
   input  logic [1:0]              i_REQ,
   input  logic [1:0]              i_MODE0,
   input  logic [1:0]              i_MODE1,
   input  logic [AW-1:0]           i_ASCII0,
   input  logic [AW-1:0]           i_ASCII1,
   input  logic [N_COLOR_BITS-1:0] i_TEXT_COLOR0,
   input  logic [N_COLOR_BITS-1:0] i_TEXT_COLOR1,
   input  logic [N_COLOR_BITS-1:0] i_BG_COLOR0,
   input  logic [N_COLOR_BITS-1:0] i_BG_COLOR1,
   input  logic                    i_OLED_READY,
   output logic                    o_OLED_START,
   output logic [1:0]              o_OLED_MODE,
   output logic [AW-1:0]           o_OLED_ASCII,
   output logic [N_COLOR_BITS-1:0] o_OLED_TEXT_COLOR,
   output logic [N_COLOR_BITS-1:0] o_OLED_BG_COLOR,
   output logic [1:0]              o_GNT,
   output logic [1:0]              o_DONE,
   output logic                    o_TIMEOUT,
   output logic                    o_BUSY
);
   localparam int CW = $clog2(TIMEOUT_CYC+1);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
   state_t state, state_nx;
   logic win, last, arb, pick, timeout_hit, done_hit;
   logic [CW-1:0] cnt;
   always_comb begin
      // the cycle carrying a DONE/TIMEOUT pulse is a mandatory gap before re-arbitration
      arb = state == IDLE && i_OLED_READY && |i_REQ && !(|o_DONE) && !o_TIMEOUT;
      pick = (i_REQ == 2'b11) ? ~last : i_REQ[1];
      timeout_hit = state == WAIT_BUSY && i_OLED_READY && cnt == CW'(TIMEOUT_CYC-1);
      done_hit = state == WAIT_DONE && i_OLED_READY;
      state_nx = state;
      case (state)
         IDLE:      state_nx = arb ? LAUNCH : IDLE;
         LAUNCH:    state_nx = WAIT_BUSY;
         WAIT_BUSY: state_nx = !i_OLED_READY ? WAIT_DONE : timeout_hit ? IDLE : WAIT_BUSY;
         WAIT_DONE: state_nx = done_hit ? IDLE : WAIT_DONE;
         default:   state_nx = IDLE;
      endcase
   end
   assign o_BUSY = state != IDLE;
   assign o_OLED_START = state == LAUNCH;
   assign o_GNT = o_BUSY ? (win ? 2'b10 : 2'b01) : 2'b00;
   always_ff @(posedge i_CLK) begin
      if (!i_RST) begin
         state <= IDLE;
         win <= 1'b0;
         last <= 1'b1;
         cnt <= '0;
         o_DONE <= 2'b00;
         o_TIMEOUT <= 1'b0;
         o_OLED_MODE <= '0;
         o_OLED_ASCII <= '0;
         o_OLED_TEXT_COLOR <= '0;
         o_OLED_BG_COLOR <= '0;
      end else begin
         state <= state_nx;
         o_DONE <= done_hit ? (win ? 2'b10 : 2'b01) : 2'b00;
         o_TIMEOUT <= timeout_hit;
         // counter reads k at the k-th cycle after LAUNCH
         cnt <= arb ? '0 : (state == LAUNCH || state == WAIT_BUSY) ? cnt + 1'b1 : cnt;
         if (done_hit || timeout_hit)
            last <= win;
         if (arb) begin
            win <= pick;
            o_OLED_MODE <= pick ? i_MODE1 : i_MODE0;
            o_OLED_ASCII <= pick ? i_ASCII1 : i_ASCII0;
            o_OLED_TEXT_COLOR <= pick ? i_TEXT_COLOR1 : i_TEXT_COLOR0;
            o_OLED_BG_COLOR <= pick ? i_BG_COLOR1 : i_BG_COLOR0;
         end
      end
   end
endmodule

// File: tb/tb_oled_frame_arbiter.sv
// tb_oled_frame_arbiter: scoreboard bench for the two-requester OLED frame arbiter.
module tb_oled_frame_arbiter;
   localparam int AW = 768;
   typedef struct {
      logic [1:0]    gnt;
      logic [1:0]    mode;
      logic [AW-1:0] ascii;
      logic [7:0]    tc;
      logic [7:0]    bg;
      logic          to;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0, ready = 1'b1;
   logic [1:0] req = 2'b00, mode0 = '0, mode1 = '0;
   logic [AW-1:0] ascii0 = '0, ascii1 = '0;
   logic [7:0] tc0 = '0, tc1 = '0, bg0 = '0, bg1 = '0;
   logic start, to_p, busy;
   logic [1:0] mode, gnt, done;
   logic [AW-1:0] ascii;
   logic [7:0] tc, bg;
   exp_t exp_q[$];
   exp_t cur;
   logic m_last = 1'b1;
   int n_tests = 0, n_fail = 0;
   oled_frame_arbiter #(.TIMEOUT_CYC(10)) dut (
      .i_CLK(clk), .i_RST(rst_n), .i_REQ(req),
      .i_MODE0(mode0), .i_MODE1(mode1), .i_ASCII0(ascii0), .i_ASCII1(ascii1),
      .i_TEXT_COLOR0(tc0), .i_TEXT_COLOR1(tc1), .i_BG_COLOR0(bg0), .i_BG_COLOR1(bg1),
      .i_OLED_READY(ready), .o_OLED_START(start), .o_OLED_MODE(mode),
      .o_OLED_ASCII(ascii), .o_OLED_TEXT_COLOR(tc), .o_OLED_BG_COLOR(bg),
      .o_GNT(gnt), .o_DONE(done), .o_TIMEOUT(to_p), .o_BUSY(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // reference arbitration: lone requester wins, tie goes to the one not served last
   task automatic push_exp(input logic [1:0] r, input logic t);
      exp_t e;
      logic w;
      for (int i = 0; i < AW/32; i++) begin
         ascii0[i*32 +: 32] = $urandom;
         ascii1[i*32 +: 32] = $urandom;
      end
      mode0 = 2'($urandom); mode1 = 2'($urandom);
      tc0 = 8'($urandom); tc1 = 8'($urandom); bg0 = 8'($urandom); bg1 = 8'($urandom);
      w = (r == 2'b11) ? ~m_last : r[1];
      e.gnt = w ? 2'b10 : 2'b01;
      e.mode = w ? mode1 : mode0;
      e.ascii = w ? ascii1 : ascii0;
      e.tc = w ? tc1 : tc0;
      e.bg = w ? bg1 : bg0;
      e.to = t;
      exp_q.push_back(e);
      m_last = w;
   endtask
   task automatic wait_start;
      int n = 0;
      do begin @(negedge clk); n++; end while (!start && n < 100);
      if (!start) check("start_wait", start, 1);
   endtask
   task automatic wait_done;
      int n = 0;
      do begin @(negedge clk); n++; end while (!(|done) && n < 100);
      if (!(|done)) check("done_wait", |done, 1);
   endtask
   task automatic run_frame(input logic [1:0] r, input int hold);
      push_exp(r, 1'b0);
      req = r;
      ready = 1'b1;
      wait_start;
      @(negedge clk) ready = 1'b0;
      repeat (hold) @(negedge clk);
      ready = 1'b1;
      wait_done;
   endtask
   always @(negedge clk) if (rst_n) begin
      if (start) begin
         if (exp_q.size() == 0) check("sb_underflow", start, 0);
         else begin
            cur = exp_q.pop_front();
            check("sb_gnt", gnt, cur.gnt);
            check("sb_mode", mode, cur.mode);
            check("sb_ascii", ascii, cur.ascii);
            check("sb_tc", tc, cur.tc);
            check("sb_bg", bg, cur.bg);
         end
      end
      if (|done) begin
         check("sb_done", done, cur.to ? 2'b00 : cur.gnt);
         check("sb_done_gnt", gnt, 0);
      end
      if (to_p) check("sb_timeout", to_p, cur.to);
      if (gnt == 2'b11) check("gnt_onehot", gnt, 2'b01);
   end
   initial begin
      logic [AW-1:0] held;
      int k;
      repeat (3) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_to", to_p, 0);
      check("rst_ascii", ascii, 0);
      rst_n = 1'b1;
      @(negedge clk);
      push_exp(2'b01, 1'b0);
      req = 2'b01;
      @(negedge clk);
      check("lat_start", start, 1);
      check("lat_gnt", gnt, 2'b01);
      req = 2'b00;
      @(negedge clk);
      check("start_1cyc", start, 0);
      ready = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_wd", busy, 1);
      check("gnt_held", gnt, 2'b01);
      ready = 1'b1;
      wait_done;
      check("done_01", done, 2'b01);
      @(negedge clk);
      check("done_1cyc", done, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1'b1;
      for (int i = 0; i < 4; i++) run_frame(2'b11, 1 + i);
      req = 2'b00;
      @(negedge clk);
      push_exp(2'b01, 1'b0);
      req = 2'b01;
      wait_start;
      held = ascii;
      @(negedge clk) ready = 1'b0;
      @(negedge clk);
      ascii0 = ~ascii0;
      req = 2'b00;
      repeat (2) @(negedge clk);
      check("stab_ascii", ascii, held);
      check("stab_gnt", gnt, 2'b01);
      ready = 1'b1;
      wait_done;
      check("stab_done", done, 2'b01);
      push_exp(2'b11, 1'b1);
      req = 2'b11;
      wait_start;
      k = 0;
      do begin @(negedge clk); k++; end while (!to_p && k < 20);
      check("to_delay", k, 10);
      check("to_gnt", gnt, 0);
      check("to_done", done, 0);
      @(negedge clk);
      check("to_1cyc", to_p, 0);
      run_frame(2'b11, 2);
      req = 2'b00;
      @(negedge clk);
      push_exp(2'b01, 1'b0);
      req = 2'b01;
      wait_start;
      @(negedge clk) ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      req = 2'b00;
      ready = 1'b1;
      @(negedge clk);
      check("mrst_gnt", gnt, 0);
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      check("mrst_ascii", ascii, 0);
      check("mrst_mode", mode, 0);
      rst_n = 1'b1;
      m_last = 1'b1;
      @(negedge clk);
      check("mrst_nodone", done, 0);
      run_frame(2'b11, 1);
      req = 2'b00;
      @(negedge clk);
      push_exp(2'b11, 1'b0);
      ready = 1'b0;
      req = 2'b11;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("blk_start", start, 0);
         check("blk_gnt", gnt, 0);
      end
      ready = 1'b1;
      wait_start;
      @(negedge clk) ready = 1'b0;
      @(negedge clk) ready = 1'b1;
      wait_done;
      req = 2'b00;
      repeat (2) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
